// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents: receiver FSM state encoding (3-bit) and frame-format constants.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5,
        S_BREAK   = 3'd6
    } rx_state_t;

    localparam int DATA_BITS   = 8;
    localparam int PARITY_EVEN = 1;

endpackage

// File: rtl/uart_rx_buffer.sv
// Synchronous FIFO, first-word fall-through, for received bytes plus tag.
// Ports:
//   i_Clock, i_Reset_n : clock, async active-low reset (empties the FIFO)
//   i_Wr_En, i_Wr_Data : push; accepted when not full, or when full with a pop
//   i_Rd_En            : pop head; ignored when empty
//   o_Rd_Data          : head entry, 0 when empty
//   o_Full, o_Empty    : status
module uart_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Wr_En,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd_En,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_Full,
    output logic             o_Empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Extra pointer MSB distinguishes full from empty.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted.
    assign w_wr_ok = i_Wr_En && (!w_full || i_Rd_En);
    assign w_rd_ok = i_Rd_En && !w_empty;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_Wr_Data;
    end

    assign o_Rd_Data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_Full    = w_full;
    assign o_Empty   = w_empty;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, even parity, 1 stop) with a byte FIFO.
// Ports:
//   i_Clock, i_Reset_n  : clock, async active-low reset
//   i_Rx_Serial         : asynchronous serial line, idles high
//   i_Rd_En             : pop FIFO head
//   i_Err_Clr           : clear sticky o_Frame_Err / o_Overrun
//   o_Rx_Byte           : FIFO head data (0 when empty)
//   o_Rx_Parity_Err     : parity-error tag of FIFO head
//   o_Rx_DV, o_Rx_Full  : FIFO not empty / full
//   o_Rx_Active         : frame in progress
//   o_Rx_Done           : one-cycle pulse per completed frame
//   o_Frame_Err         : sticky, stop bit sampled low
//   o_Overrun           : sticky, valid frame dropped because FIFO full
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | half-bit wait, confirm start bit at its middle
// DATA    | sample D0..D7 at mid-bit
// PARITY  | sample parity bit, latch parity error
// STOP    | sample stop bit, push byte or flag framing error
// CLEANUP | one cycle after a good stop bit
// BREAK   | stop bit was low; wait for line high before re-arming
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DEPTH        = 8
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_Serial,
    input  logic       i_Rd_En,
    input  logic       i_Err_Clr,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Parity_Err,
    output logic       o_Rx_DV,
    output logic       o_Rx_Full,
    output logic       o_Rx_Active,
    output logic       o_Rx_Done,
    output logic       o_Frame_Err,
    output logic       o_Overrun
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic        r_rx_meta;
    logic        r_rx_s;
    rx_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_idx;
    logic        r_par;
    logic        r_perr;
    logic [7:0]  r_shift;
    logic        r_done;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_bit_end;
    logic        w_stop_sample;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [8:0]  w_rd_data;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_bit_end     = (r_cnt == LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_end;
    assign w_push        = w_stop_sample && r_rx_s;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    r_par <= 1'b0;
                    if (!r_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        r_par          <= r_par ^ r_rx_s;
                        if (r_idx == IDX_LAST) r_state <= S_PARITY;
                        else                   r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_perr  <= r_par ^ r_rx_s ^ (PARITY_EVEN == 0);
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= r_rx_s ? S_CLEANUP : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CLEANUP: r_state <= S_IDLE;
                S_BREAK:   if (r_rx_s) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_stop_sample && !r_rx_s) r_frame_err <= 1'b1;
            else if (i_Err_Clr)           r_frame_err <= 1'b0;
            // A simultaneous pop makes room, so that case is not an overrun.
            if (w_push && w_full && !i_Rd_En) r_overrun <= 1'b1;
            else if (i_Err_Clr)               r_overrun <= 1'b0;
        end
    end

    uart_rx_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_buffer (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Wr_En   (w_push),
        .i_Wr_Data ({r_perr, r_shift}),
        .i_Rd_En   (i_Rd_En),
        .o_Rd_Data (w_rd_data),
        .o_Full    (w_full),
        .o_Empty   (w_empty)
    );

    assign o_Rx_Byte       = w_rd_data[7:0];
    assign o_Rx_Parity_Err = w_rd_data[8];
    assign o_Rx_DV         = !w_empty;
    assign o_Rx_Full       = w_full;
    assign o_Rx_Active     = (r_state != S_IDLE);
    assign o_Rx_Done       = r_done;
    assign o_Frame_Err     = r_frame_err;
    assign o_Overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Parity_Err, o_Rx_DV, o_Rx_Full, o_Rx_Active;
    logic       o_Rx_Done, o_Frame_Err, o_Overrun;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Rx_Serial    (rx),
        .i_Rd_En        (rd_en),
        .i_Err_Clr      (err_clr),
        .o_Rx_Byte      (o_Rx_Byte),
        .o_Rx_Parity_Err(o_Rx_Parity_Err),
        .o_Rx_DV        (o_Rx_DV),
        .o_Rx_Full      (o_Rx_Full),
        .o_Rx_Active    (o_Rx_Active),
        .o_Rx_Done      (o_Rx_Done),
        .o_Frame_Err    (o_Frame_Err),
        .o_Overrun      (o_Overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_Rx_Done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; tick(CPB);
        end
        rx = p; tick(CPB);
        rx = s; tick(CPB);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [8:0] e;
        check({name, " dv"}, 32'(o_Rx_DV), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({name, " byte"}, 32'(o_Rx_Byte), 32'(e[7:0]));
            check({name, " perr"}, 32'(o_Rx_Parity_Err), 32'(e[8]));
            pulse_rd();
        end
    endtask

    vec_t vecs[8];
    int   d0;
    logic ovr_exp;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset outputs",
              {o_Rx_Byte, o_Rx_Parity_Err, o_Rx_DV, o_Rx_Full, o_Rx_Active,
               o_Rx_Done, o_Frame_Err, o_Overrun}, 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Table-driven frames
        foreach (vecs[k]) begin
            d0 = done_cnt;
            send_frame(vecs[k].data, (^vecs[k].data) ^ vecs[k].bad_par, vecs[k].stop);
            if (!vecs[k].stop) begin
                tick(20);
                check($sformatf("v%0d break hold active", k), 32'(o_Rx_Active), 32'd1);
                check($sformatf("v%0d break no push", k), 32'(o_Rx_DV), 32'd0);
                rx = 1'b1;
            end
            tick(4);
            if (vecs[k].exp_push) exp_q.push_back({vecs[k].exp_perr, vecs[k].data});
            check($sformatf("v%0d idle", k), 32'(o_Rx_Active), 32'd0);
            check($sformatf("v%0d done pulses", k), 32'(done_cnt - d0), 32'd1);
            check($sformatf("v%0d frame_err", k), 32'(o_Frame_Err), 32'(vecs[k].exp_ferr));
            pop_check($sformatf("v%0d pop", k));
            check($sformatf("v%0d dv after pop", k), 32'(o_Rx_DV), 32'd0);
            pulse_clr();
            check($sformatf("v%0d err cleared", k), 32'(o_Frame_Err), 32'd0);
            tick(2);
        end

        // Overrun: 9 frames, no pops
        ovr_exp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
            else                      ovr_exp = 1'b1;
            tick(3);
        end
        check("ovr full", 32'(o_Rx_Full), 32'd1);
        check("ovr flag", 32'(o_Overrun), 32'(ovr_exp));
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovr pop%0d", i));
        check("ovr drained", 32'(o_Rx_DV), 32'd0);
        check("ovr not full", 32'(o_Rx_Full), 32'd0);
        pulse_rd();
        check("pop empty dv", 32'(o_Rx_DV), 32'd0);
        check("pop empty byte", 32'(o_Rx_Byte), 32'd0);
        check("ovr before clr", 32'(o_Overrun), 32'(ovr_exp));
        pulse_clr();
        check("ovr cleared", 32'(o_Overrun), 32'd0);

        // Glitch: one-cycle low pulse with a byte buffered
        send_frame(8'h42, ^8'h42, 1'b1);
        exp_q.push_back({1'b0, 8'h42});
        tick(4);
        d0 = done_cnt;
        rx = 1'b0; tick(1); rx = 1'b1; tick(8);
        check("glitch done", 32'(done_cnt - d0), 32'd0);
        check("glitch flags", {30'd0, o_Frame_Err, o_Overrun}, 32'd0);
        check("glitch active", 32'(o_Rx_Active), 32'd0);
        check("glitch fifo head", {o_Rx_DV, o_Rx_Byte}, {1'b1, exp_q[0][7:0]});

        // Reset during D4 with 2 bytes buffered
        send_frame(8'h99, ^8'h99, 1'b1);
        exp_q.push_back({1'b0, 8'h99});
        tick(4);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 8'hE7 >> i; tick(CPB);
        end
        rx = 1'b0; tick(2);
        check("pre-reset active", 32'(o_Rx_Active), 32'd1);
        rst_n = 1'b0; rx = 1'b1;
        #1;
        check("midframe reset outputs",
              {o_Rx_Byte, o_Rx_Parity_Err, o_Rx_DV, o_Rx_Full, o_Rx_Active,
               o_Rx_Done, o_Frame_Err, o_Overrun}, 32'h0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(3);
        d0 = done_cnt;
        send_frame(8'hC3, ^8'hC3, 1'b1);
        exp_q.push_back({1'b0, 8'hC3});
        tick(4);
        check("post-reset done", 32'(done_cnt - d0), 32'd1);
        pop_check("post-reset pop");
        check("post-reset empty", 32'(o_Rx_DV), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver paired with the team's FIFO-buffered UART transmitter; it consumes the line that transmitter drives.
- Frame format: start 0, D0..D7 LSB first, even parity bit (XOR of D0..D7), stop 1.
- Synchronises the line and samples at mid-bit. Checks parity and stop bit.
- Buffers received bytes, each tagged with its parity-error flag, in an internal FIFO that the bus/CPU side pops.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (clock freq / baud); minimum 4.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Rx_Serial  in  1  asynchronous serial line; idles high
- i_Rd_En  in  1  pop FIFO head; ignored when empty
- i_Err_Clr  in  1  clears sticky o_Frame_Err and o_Overrun
- o_Rx_Byte  out  8  FIFO head data, first-word fall-through; 0 when empty
- o_Rx_Parity_Err  out  1  parity-error tag of FIFO head
- o_Rx_DV  out  1  FIFO not empty
- o_Rx_Full  out  1  FIFO full
- o_Rx_Active  out  1  frame in progress (state is not IDLE)
- o_Rx_Done  out  1  one-cycle pulse when a frame completes, good or bad
- o_Frame_Err  out  1  sticky: stop bit sampled 0
- o_Overrun  out  1  sticky: valid frame arrived while FIFO full

Behaviour:
- Reset values: all outputs 0; synchroniser flops 1; FIFO empty; state IDLE.
- Reset mid-frame aborts the frame and discards it.
- Synchroniser: 2 flops on i_Rx_Serial. "rx_s" below is the second flop. All sampling uses rx_s.
- Counters:
  - Bit-timer cnt is $clog2(CLKS_PER_BIT) bits wide. HALF = (CLKS_PER_BIT-1)/2.
  - Bit index is 3 bits. Parity accumulator is 1 bit.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK.
  - IDLE: cnt=0, idx=0, par=0. rx_s==0 -> START.
  - START: cnt counts up. At cnt==HALF, sample: 1 -> IDLE (glitch, no flags); 0 -> cnt=0, DATA. From here sampling is mid-bit.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[idx] (LSB first), par^=rx_s, cnt=0. idx==7 -> PARITY, else idx+1.
  - PARITY: at cnt==CLKS_PER_BIT-1, perr = par ^ rx_s, cnt=0 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1: push {perr, shift} if not full; if full, set o_Overrun and drop the byte. -> CLEANUP.
    - 0: set o_Frame_Err, drop the byte. -> BREAK.
  - CLEANUP: one cycle; o_Rx_Done=1 -> IDLE.
  - BREAK: o_Rx_Done=1 on entry cycle only. Wait for rx_s==1 -> IDLE, so a held-low line is never treated as a new start.
- Latency: the push is registered in the STOP sample cycle. o_Rx_DV rises the next cycle. o_Rx_Done is high in the cycle after the push.
- FIFO:
  - DEPTH x 9 bits; read and write pointers are $clog2(DEPTH)+1 bits; wrap-around is natural modulo.
  - Full when pointer MSBs differ and the rest are equal. Empty when the pointers are equal.
  - Pop and push in the same cycle while full: both proceed, no overrun.
  - Pop and push in the same cycle while empty: the push proceeds and the pop is ignored.
  - Pop when empty: no effect.
- Sticky flags: i_Err_Clr clears them. If a set and i_Err_Clr occur in the same cycle, set wins.
- No timing requirement beyond the 2-flop synchroniser; a baud mismatch of up to ±2% must still sample correctly.

Decomposition:
- Shared package (uart_pkg): state encodings (3-bit), frame constants: DATA_BITS=8, PARITY_EVEN=1.
- One sub-module: uart_rx_buffer (parameterised DEPTH/WIDTH=9 sync FIFO, FWFT, async active-low reset, full/empty). The FSM stays in uart_rx_fifo.

Test Plan:
- CLKS_PER_BIT=4, send 0xA5 with parity 0 and stop 1 -> o_Rx_DV=1, o_Rx_Byte=0xA5, o_Rx_Parity_Err=0, one o_Rx_Done pulse; i_Rd_En -> o_Rx_DV=0.
- Send 0x01 with parity bit 0 (wrong) -> byte 0x01 stored, o_Rx_Parity_Err=1, o_Frame_Err=0.
- Send 0x3C with stop bit 0, line held low for 20 cycles -> no push, o_Frame_Err=1, stays in BREAK until high. The next valid frame 0x55 is received correctly.
- Send 9 valid frames 0x10..0x18 with no pops (DEPTH=8) -> o_Rx_Full=1, o_Overrun=1. Popping returns 0x10..0x17 in order. i_Err_Clr clears o_Overrun.
- Pulse i_Rx_Serial low for 1 cycle -> START aborts at HALF; no o_Rx_Done, no flags, FIFO unchanged.
- Assert i_Reset_n=0 during D4 of a frame with 2 bytes buffered -> all outputs 0 and FIFO empty immediately; after release, the next frame 0xC3 is received correctly.
